// File: rtl/sdhci_pkg.sv
// Shared types and constants for the SDHCI CRC engines.
//   crc_state_e : frame sequencer states (IDLE, CALC, OUT, CHECK)
//   CRC7_*      : CMD line CRC7 width and polynomial (x^7 + x^3 + 1)
//   CRC16_*     : DAT line CRC16-CCITT width and polynomial
package sdhci_pkg;

    localparam int unsigned CRC7_W  = 7;
    localparam int unsigned CRC16_W = 16;

    localparam logic [CRC7_W-1:0]  CRC7_POLY  = 7'h09;
    localparam logic [CRC16_W-1:0] CRC16_POLY = 16'h1021;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        OUT   = 2'd2,
        CHECK = 2'd3
    } crc_state_e;

endpackage

// File: rtl/sdhci_crc_lane.sv
// One serial CRC lane: remainder register plus sticky mismatch flag.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : zero remainder and error flag (highest priority)
//   upd_i         : absorb dat_i into the remainder (LFSR step)
//   shf_i         : shift remainder left with zero fill
//   cmp_i         : with shf_i, compare dat_i to the outgoing MSb
//   dat_i         : serial bit for this lane
//   msb_o         : remainder MSb (next CRC bit on the line)
//   err_o         : sticky mismatch flag
module sdhci_crc_lane
    import sdhci_pkg::*;
#(
    parameter int unsigned         CrcWidth = CRC7_W,
    parameter logic [CrcWidth-1:0] Poly     = CRC7_POLY
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic upd_i,
    input  logic shf_i,
    input  logic cmp_i,
    input  logic dat_i,
    output logic msb_o,
    output logic err_o
);

    logic [CrcWidth-1:0] rem_q;
    logic [CrcWidth-1:0] rem_d;
    logic [CrcWidth-1:0] rem_shl;
    logic                err_q;
    logic                err_d;

    // Shift expressed as a shift operator so CrcWidth == 1 stays legal.
    assign rem_shl = rem_q << 1;
    assign msb_o   = rem_q[CrcWidth-1];
    assign err_o   = err_q;

    // Next remainder / error: clear, absorb, or shift-out (with optional compare).
    always_comb begin
        rem_d = rem_q;
        err_d = err_q;
        if (clr_i) begin
            rem_d = '0;
            err_d = 1'b0;
        end else if (upd_i) begin
            rem_d = (dat_i ^ rem_q[CrcWidth-1]) ? (rem_shl ^ Poly) : rem_shl;
        end else if (shf_i) begin
            rem_d = rem_shl;
            if (cmp_i && (dat_i != rem_q[CrcWidth-1])) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q <= '0;
            err_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/sdhci_crc_lanes.sv
// Multi-lane serial CRC generator/checker with frame-level sequencing.
// Optional feature macro: SDHCI_CRC_CHECK_EN (CHECK state, compare, crc_err_o).
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   start_i       : clear lanes and enter CALC (any state, top priority)
//   valid_i       : dat_i carries one bit per lane this cycle
//   dat_i         : serial data, one bit per lane
//   end_i         : payload done, shift CRC out (OUT)
//   chk_i         : payload done, compare incoming CRC (CHECK)
//   crc_o         : remainder MSb per lane
//   crc_valid_o   : crc_o is a CRC bit to drive
//   busy_o        : sequencer not IDLE
//   done_o        : one-cycle pulse at end of OUT or CHECK
//   crc_err_o     : sticky per-lane mismatch from the last CHECK
module sdhci_crc_lanes
    import sdhci_pkg::*;
#(
    parameter int unsigned         CrcWidth = CRC7_W,
    parameter logic [CrcWidth-1:0] Poly     = CRC7_POLY,
    parameter int unsigned         NumLanes = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                valid_i,
    input  logic [NumLanes-1:0] dat_i,
    input  logic                end_i,
    input  logic                chk_i,
    output logic [NumLanes-1:0] crc_o,
    output logic                crc_valid_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [NumLanes-1:0] crc_err_o
);

    localparam int unsigned     CntW    = $clog2(CrcWidth + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(CrcWidth - 1);

    if (CrcWidth < 1 || CrcWidth > 32) begin : g_bad_width
        $error("sdhci_crc_lanes: CrcWidth must be within 1..32");
    end
    if (Poly[0] != 1'b1) begin : g_bad_poly
        $error("sdhci_crc_lanes: Poly bit 0 must be set");
    end
    if (NumLanes < 1) begin : g_bad_lanes
        $error("sdhci_crc_lanes: NumLanes must be at least 1");
    end

    crc_state_e          state_q;
    crc_state_e          state_d;
    logic [CntW-1:0]     cnt_q;
    logic [CntW-1:0]     cnt_d;
    logic                lane_clr;
    logic                lane_upd;
    logic                lane_shf;
    logic                lane_cmp;
    logic [NumLanes-1:0] lane_err;

`ifdef SDHCI_CRC_CHECK_EN
    // Set after the last compared bit; CHECK then spends one cycle on done_o.
    logic last_q;
    logic last_d;
`endif

    // Next-state and lane controls; start_i overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lane_clr = 1'b0;
        lane_upd = 1'b0;
        lane_shf = 1'b0;
        lane_cmp = 1'b0;
`ifdef SDHCI_CRC_CHECK_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            CALC: begin
                lane_upd = valid_i;
                if (end_i) begin
                    state_d = OUT;
                    cnt_d   = CntLoad;
                end
`ifdef SDHCI_CRC_CHECK_EN
                else if (chk_i) begin
                    state_d = CHECK;
                    cnt_d   = CntLoad;
                    last_d  = 1'b0;
                end
`endif
            end
            OUT: begin
                lane_shf = 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
`ifdef SDHCI_CRC_CHECK_EN
            CHECK: begin
                if (last_q) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end else if (valid_i) begin
                    lane_shf = 1'b1;
                    lane_cmp = 1'b1;
                    if (cnt_q == '0) begin
                        last_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_i) begin
            state_d  = CALC;
            cnt_d    = '0;
            lane_clr = 1'b1;
            lane_upd = 1'b0;
            lane_shf = 1'b0;
            lane_cmp = 1'b0;
`ifdef SDHCI_CRC_CHECK_EN
            last_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SDHCI_CRC_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Independent lanes driven by the shared sequencer.
    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        sdhci_crc_lane #(
            .CrcWidth (CrcWidth),
            .Poly     (Poly)
        ) u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (lane_clr),
            .upd_i  (lane_upd),
            .shf_i  (lane_shf),
            .cmp_i  (lane_cmp),
            .dat_i  (dat_i[l]),
            .msb_o  (crc_o[l]),
            .err_o  (lane_err[l])
        );
    end

    assign crc_valid_o = (state_q == OUT);
    assign busy_o      = (state_q != IDLE);

`ifdef SDHCI_CRC_CHECK_EN
    assign done_o    = ((state_q == OUT) && (cnt_q == '0)) || ((state_q == CHECK) && last_q);
    assign crc_err_o = lane_err;
`else
    // Without the checker chk_i has no effect and the error flags never set.
    logic chk_unused;
    logic err_unused;
    assign chk_unused = chk_i;
    assign err_unused = ^lane_err;
    assign done_o     = (state_q == OUT) && (cnt_q == '0);
    assign crc_err_o  = '0;
`endif

endmodule
